ofm_pad_writer: RTL and testbench
=================================

# ofm_pad_writer

Downstream companion of the layer-1 PE cluster in the MB-CONV subsystem. Accepts 16-channel OFM words (16 × 8-bit, packed 128-bit) as the cluster finishes each output pixel and writes them into the 128-bit-input layer-2 IFM BRAM. Walks the padded feature map in raster order, so border positions receive zero words, and generates every BRAM write address itself. A 4-deep input FIFO absorbs cluster bursts while border zeros are being written.

## Interface
- DATA_W, 128, OFM word width ({OFM_15..OFM_0}, OFM_0 in bits [7:0])
- ADDR_W, 32, BRAM write-address width
- FIFO_DEPTH, 4, input FIFO entries (power of two)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a tile (sampled in IDLE only)
- OFM_W  in  8  unpadded output width = height; 0 is illegal
- pad  in  2  border width 0..3
- base_addr  in  ADDR_W  BRAM word address of padded position (0,0)
- valid_in  in  1  one-cycle push of data_in
- data_in  in  DATA_W  16 OFM bytes of one pixel
- wr_en  out  1  BRAM write strike (wr_rd_en of layer-2 BRAM)
- wr_addr  out  ADDR_W  BRAM write address
- wr_data  out  DATA_W  word written (zero on border)
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse with the final write
- err  out  1  sticky protocol error

## Operation
- PW = OFM_W + 2·pad, computed at 9 bits; positions = PW², linear index 0..PW²−1. Address = base_addr + index (ADDR_W wrap-around, no saturation).
- Position (r,c) is interior iff pad ≤ r < pad+OFM_W and pad ≤ c < pad+OFM_W; all others are border.
- States: IDLE → RUN on start with OFM_W≠0 (start with OFM_W=0 is ignored and sets err). In RUN, each cycle:
  - border: issue zero write, advance;
  - interior, FIFO non-empty: pop head, write it, advance;
  - interior, FIFO empty: stall, no write.
- After the last position is advanced, RUN → DONE (one cycle) → IDLE.
- OFM_W, pad and base_addr are latched on start; later changes have no effect until the next start.
- FIFO: push on valid_in in RUN. If a push and a pop occur in the same cycle while full, both take effect.
- err is set by any of:
  - a push while full with no pop in that cycle (word dropped);
  - valid_in in IDLE/DONE (dropped);
  - more than OFM_W² pushes in one tile (excess dropped).
- err is cleared by reset or an accepted start. start in RUN/DONE is ignored without error.
- pad=0: pure sequential copy, OFM_W² writes.

## Timing
- Reset: state IDLE, FIFO empty, counters 0. wr_en, wr_addr, wr_data, busy, done and err all 0, effective immediately and asynchronously. Reset mid-tile aborts it with no further writes.
- wr_en, wr_addr, wr_data and done are registered: a decision in cycle k appears in cycle k+1.
- start in cycle c → busy high from c+1. The first position is decided in c+1, and its write (wr_en) appears in c+2.
- Border runs: one write per cycle, no bubbles.
- valid_in in cycle c with the writer waiting at an interior position: FIFO count 1 in c+1, pop in c+1, wr_en in c+2.
- Unstalled tile: start in c → last write and done in c+1+PW², busy low from c+2+PW².
- wr_en is never high in IDLE. Each position is written exactly once, in raster order.

## Test plan
- OFM_W=2, pad=1, base=0x100, pushes D0..D3 pre-loaded immediately after start:
  - expect 16 writes, 0x100..0x10F;
  - D0..D3 at 0x105, 0x106, 0x109, 0x10A; zeros elsewhere;
  - done with the 0x10F write; err=0.
- OFM_W=3, pad=0, base=0: 9 pushes spaced 5 cycles apart → 9 writes at 0..8, data in push order. Stalls between writes with wr_en=0.
- Overflow: OFM_W=4, pad=3 (first interior at index 33); push 5 words during the leading border → err=1 after the 5th push. Fifth word dropped; first four land at interior addresses 33..36.
- valid_in in IDLE → err=1, no write. A following start clears err.
- Reset asserted mid-tile (after 7 writes) → wr_en, busy, done go 0 at once. After release, a fresh start runs a full tile from base_addr.
- start with OFM_W=0 → stays IDLE, err=1, no writes.

Source files
------------

// File: rtl/ofm_pad_writer.sv
// ofm_pad_writer: streams OFM pixel words into the layer-2 IFM BRAM, walking
// the padded feature map in raster order and zero-filling border positions.
module ofm_pad_writer #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        OFM_W,
  input  logic [1:0]        pad,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | walking padded positions, one decision per cycle
  // DONE  | final write on the bus, back to IDLE next cycle
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]        ofm_w_q;
  logic [1:0]        pad_q;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        row, col;
  logic [17:0]       pos_left;
  logic [15:0]       push_cnt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    fifo_cnt;

  logic [8:0]  pw_new, pw_q, pad9, int_end;
  logic [17:0] pos_new;
  logic [15:0] tile_px;
  logic        start_ok, interior, fifo_empty, fifo_full, pop, advance, last;
  logic        push_req, over_lim, push, err_set;

  // Padded width is 9 bits wide so 255 + 6 does not wrap.
  assign pw_new     = {1'b0, OFM_W} + {6'b0, pad, 1'b0};
  assign pos_new    = ({9'b0, pw_new} * {9'b0, pw_new}) - 18'd1;
  assign pw_q       = {1'b0, ofm_w_q} + {6'b0, pad_q, 1'b0};
  assign pad9       = {7'b0, pad_q};
  assign int_end    = pad9 + {1'b0, ofm_w_q};
  assign tile_px    = {8'b0, ofm_w_q} * {8'b0, ofm_w_q};
  assign interior   = (row >= pad9) && (row < int_end) && (col >= pad9) && (col < int_end);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign last       = (pos_left == 18'd0);
  assign busy       = (state != IDLE);

  // Accepted pushes are capped at OFM_W^2; beyond that words are dropped.
  assign push_req = valid_in && (state == RUN);
  assign over_lim = (push_cnt == tile_px);
  assign push     = push_req && !over_lim && (!fifo_full || pop);
  assign err_set  = (valid_in && (state != RUN)) ||
                    (push_req && over_lim) ||
                    (push_req && !over_lim && fifo_full && !pop) ||
                    ((state == IDLE) && start && (OFM_W == 8'd0));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-cycle position decision
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    pop       = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (OFM_W != 8'd0)) begin
          start_ok  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        pop     = interior && !fifo_empty;
        advance = !interior || pop;
        if (advance && last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Raster walker: latches tile geometry on start, steps once per advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ofm_w_q  <= '0;
      pad_q    <= '0;
      addr_q   <= '0;
      row      <= '0;
      col      <= '0;
      pos_left <= '0;
    end else if (start_ok) begin
      ofm_w_q  <= OFM_W;
      pad_q    <= pad;
      addr_q   <= base_addr;
      row      <= '0;
      col      <= '0;
      pos_left <= pos_new;
    end else if (advance) begin
      addr_q   <= addr_q + ADDR_W'(1);
      pos_left <= pos_left - 18'd1;
      if (col == pw_q - 9'd1) begin
        col <= '0;
        row <= row + 9'd1;
      end else begin
        col <= col + 9'd1;
      end
    end
  end

  // FIFO pointers, occupancy and per-tile push count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      push_cnt <= '0;
    end else if (start_ok) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      push_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        push_cnt <= push_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage, no reset needed since occupancy guards every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Registered BRAM write port and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en   <= advance;
      wr_addr <= addr_q;
      wr_data <= pop ? mem[rd_ptr] : '0;
      done    <= advance && last;
    end
  end

  // Sticky protocol error; a new error in the same cycle wins over the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err <= 1'b0;
    else if (err_set)  err <= 1'b1;
    else if (start_ok) err <= 1'b0;
  end
endmodule

// File: tb/tb_ofm_pad_writer.sv
// Testbench for ofm_pad_writer: randomized tiles checked against a raster
// model of the padded map built from the tile geometry and pushed words.
module tb_ofm_pad_writer;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset, start, valid_in;
  logic [7:0]    ofm_w;
  logic [1:0]    pad;
  logic [AW-1:0] base_addr;
  logic [DW-1:0] data_in;
  logic          wr_en, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model and observation state
  int            m_w, m_p;
  logic [AW-1:0] m_base;
  logic [DW-1:0] m_words[$];
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  bit            got_done[$];
  int            got_cyc[$];
  int done_cnt, done_cyc, int_seen, pushes_acc, start_cyc;
  int idle_wr = 0;

  ofm_pad_writer #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .OFM_W(ofm_w), .pad(pad),
    .base_addr(base_addr), .valid_in(valid_in), .data_in(data_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic bit is_interior(int idx);
    int pw, r, c;
    pw = m_w + 2 * m_p;
    if (pw <= 0 || idx < 0 || idx >= pw * pw) return 1'b0;
    r = idx / pw;
    c = idx % pw;
    return (r >= m_p) && (r < m_p + m_w) && (c >= m_p) && (c < m_p + m_w);
  endfunction

  // capture every write shortly after the edge
  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      got_done.push_back(done);
      got_cyc.push_back(cyc);
      if (!busy) idle_wr++;
      if (is_interior(int'(wr_addr - m_base))) int_seen++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // compares captured writes with the padded raster expected from the model
  function automatic int tile_diff(output string msg);
    int n, wi, bad;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    n = (m_w + 2 * m_p) * (m_w + 2 * m_p);
    wi = 0;
    bad = 0;
    msg = "";
    if (got_addr.size() != n) begin
      msg = $sformatf("write count %0d vs %0d", got_addr.size(), n);
      return 1;
    end
    for (int i = 0; i < n; i++) begin
      ea = m_base + AW'(i);
      ed = '0;
      if (is_interior(i)) begin
        if (wi < m_words.size()) ed = m_words[wi];
        else bad++;
        wi++;
      end
      if (got_addr[i] !== ea || got_data[i] !== ed || got_done[i] !== (i == n - 1)) begin
        if (bad == 0)
          msg = $sformatf("idx %0d addr %0h/%0h data %0h/%0h done %0d",
                          i, got_addr[i], ea, got_data[i], ed, got_done[i]);
        bad++;
      end
    end
    return bad;
  endfunction

  task automatic clear_obs();
    got_addr.delete(); got_data.delete(); got_done.delete(); got_cyc.delete();
    m_words.delete();
    done_cnt = 0; done_cyc = -1; int_seen = 0; pushes_acc = 0;
  endtask

  task automatic kick(input int w, input int p, input logic [AW-1:0] base);
    @(negedge clk);
    clear_obs();
    m_w = w; m_p = p; m_base = base;
    ofm_w = 8'(w); pad = 2'(p); base_addr = base; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    ofm_w = 8'($urandom_range(1, 255));
    pad = 2'($urandom_range(0, 3));
    base_addr = $urandom();
  endtask

  task automatic push_word(input logic [DW-1:0] d, input bit keep);
    valid_in = 1'b1;
    data_in = d;
    if (keep) begin
      m_words.push_back(d);
      pushes_acc++;
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // mode 0: back-to-back, 1: spaced 5 cycles, 2: random gaps
  task automatic drive_pushes(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      int g;
      g = 0;
      if (mode == 1 && k > 0) repeat (4) @(negedge clk);
      else if (mode == 2) repeat ($urandom_range(0, 3)) @(negedge clk);
      while (pushes_acc - int_seen >= FD && g < 1000) begin
        @(negedge clk);
        g++;
      end
      push_word(rnd_word(), 1'b1);
    end
  endtask

  task automatic wait_done(output bit timed_out);
    int g;
    g = 0;
    while (done_cnt == 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    timed_out = (done_cnt == 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; valid_in = 1'b0; ofm_w = '0; pad = '0;
    base_addr = '0; data_in = '0;
    clear_obs();
    m_w = 0; m_p = 0; m_base = '0;
    #22;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0h expected 0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %0h expected 0", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_pad1_preload();
    bit to;
    int nb;
    string msg;
    kick(2, 1, 32'h100);
    drive_pushes(4, 0);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL pad1_done_timeout: got no done expected done"); end
    nb = tile_diff(msg);
    checks++; if (nb !== 0) begin errors++; $display("FAIL pad1_writes: %0d bad, %s", nb, msg); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL pad1_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc !== start_cyc + 1 + 16) begin errors++; $display("FAIL pad1_done_cycle: got %0d expected %0d", done_cyc, start_cyc + 17); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pad1_busy_at_done: got %0b expected 1", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pad1_err: got %0b expected 0", err); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pad1_busy_after: got %0b expected 0", busy); end
  endtask

  task automatic test_stall_copy();
    bit to;
    int nb, badgap;
    string msg;
    kick(3, 0, 32'h0);
    drive_pushes(9, 1);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL copy_done_timeout: got no done expected done"); end
    nb = tile_diff(msg);
    checks++; if (nb !== 0) begin errors++; $display("FAIL copy_writes: %0d bad, %s", nb, msg); end
    badgap = 0;
    for (int i = 1; i < got_cyc.size(); i++)
      if (got_cyc[i] - got_cyc[i-1] != 5) badgap++;
    checks++; if (badgap !== 0) begin errors++; $display("FAIL copy_spacing: got %0d gaps not 5 expected 0", badgap); end
  endtask

  task automatic test_idle_valid();
    bit to;
    int nb;
    string msg;
    @(negedge clk);
    @(negedge clk);
    clear_obs();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL idle_err_before: got %0b expected 0", err); end
    push_word(rnd_word(), 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL idle_valid_err: got %0b expected 1", err); end
    checks++; if (got_addr.size() !== 0) begin errors++; $display("FAIL idle_valid_writes: got %0d expected 0", got_addr.size()); end
    kick(1, 1, $urandom());
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL start_clears_err: got %0b expected 0", err); end
    drive_pushes(1, 2);
    wait_done(to);
    nb = tile_diff(msg);
    checks++; if (to || nb !== 0) begin errors++; $display("FAIL idle_followup_tile: timeout %0b, %0d bad, %s", to, nb, msg); end
  endtask

  task automatic test_overflow();
    bit to;
    int nb;
    string msg;
    logic [AW-1:0] b;
    b = $urandom();
    kick(4, 3, b);
    for (int k = 0; k < 4; k++) push_word(rnd_word(), 1'b1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_after_4: got %0b expected 0", err); end
    push_word(rnd_word(), 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err_after_5: got %0b expected 1", err); end
    drive_pushes(12, 2);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL ovf_done_timeout: got no done expected done"); end
    nb = tile_diff(msg);
    checks++; if (nb !== 0) begin errors++; $display("FAIL ovf_writes: %0d bad, %s", nb, msg); end
    if (got_addr.size() > 36) begin
      checks++;
      if (got_addr[33] !== b + 32'd33 || got_data[33] !== m_words[0] || got_data[36] !== m_words[3]) begin
        errors++;
        $display("FAIL ovf_first_interior: got addr %0h data %0h expected addr %0h data %0h",
                 got_addr[33], got_data[33], b + 32'd33, m_words[0]);
      end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %0b expected 1", err); end
  endtask

  task automatic test_random();
    bit to;
    int nb, w, p;
    string msg;
    for (int t = 0; t < 6; t++) begin
      w = $urandom_range(1, 6);
      p = $urandom_range(0, 3);
      kick(w, p, $urandom());
      // a start while RUN must be ignored, and is harmless to the tile
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive_pushes(w * w, 2);
      wait_done(to);
      nb = tile_diff(msg);
      checks++; if (to || nb !== 0) begin errors++; $display("FAIL rand_tile w=%0d p=%0d: timeout %0b, %0d bad, %s", w, p, to, nb, msg); end
      checks++; if (err !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL rand_err_done w=%0d p=%0d: got err %0b done %0d expected 0 1", w, p, err, done_cnt); end
    end
  endtask

  task automatic test_wrap();
    bit to;
    int nb;
    string msg;
    kick(2, 1, 32'hFFFF_FFF8);
    drive_pushes(4, 2);
    wait_done(to);
    nb = tile_diff(msg);
    checks++; if (to || nb !== 0) begin errors++; $display("FAIL wrap_tile: timeout %0b, %0d bad, %s", to, nb, msg); end
  endtask

  task automatic test_reset_mid_tile();
    bit to;
    int nb, g;
    string msg;
    logic [AW-1:0] b;
    b = $urandom();
    kick(3, 1, b);
    push_word(rnd_word(), 1'b1);
    g = 0;
    while (got_addr.size() < 7 && g < 200) begin
      @(negedge clk);
      g++;
    end
    checks++; if (got_addr.size() !== 7) begin errors++; $display("FAIL mid_pre_writes: got %0d expected 7", got_addr.size()); end
    reset = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got wr_en %0b busy %0b done %0b expected 0 0 0", wr_en, busy, done); end
    repeat (3) @(negedge clk);
    checks++; if (got_addr.size() !== 7) begin errors++; $display("FAIL mid_no_writes: got %0d expected 7", got_addr.size()); end
    reset = 1'b0;
    kick(3, 1, b);
    drive_pushes(9, 2);
    wait_done(to);
    nb = tile_diff(msg);
    checks++; if (to || nb !== 0) begin errors++; $display("FAIL mid_fresh_tile: timeout %0b, %0d bad, %s", to, nb, msg); end
  endtask

  task automatic test_zero_width();
    @(negedge clk);
    @(negedge clk);
    clear_obs();
    ofm_w = 8'd0; pad = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %0b expected 0", busy); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL zero_err: got %0b expected 1", err); end
    checks++; if (got_addr.size() !== 0 || done_cnt !== 0) begin errors++; $display("FAIL zero_writes: got %0d writes %0d done expected 0 0", got_addr.size(), done_cnt); end
    checks++; if (idle_wr !== 0) begin errors++; $display("FAIL wr_en_in_idle: got %0d expected 0", idle_wr); end
  endtask

  initial begin
    test_reset();
    test_pad1_preload();
    test_stall_copy();
    test_idle_valid();
    test_overflow();
    test_random();
    test_wrap();
    test_reset_mid_tile();
    test_zero_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
